// File: rtl/ps2_key_buffer.sv
// ps2_key_buffer: decodes PS/2 set-2 scancodes into 10-bit key events
// ({release, extended, code}) and queues them for the CPU behind a
// STATUS/DATA register pair.
// Optional feature macro: KB_REPEAT_FILTER_EN (drops typematic repeats of held keys).
`timescale 1ns/1ps
module ps2_key_buffer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        kb_valid_in,
  input  logic [7:0]  kb_scancode_in,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  output logic [31:0] cpu_data_out,
  output logic        key_pending_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 10;
  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_REL = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_REL, S_EXT_REL} state_e;

  state_e          state_q, state_d;
  logic            ev_valid_c;
  logic [EW-1:0]   ev_word_c;
  logic            push_req_c;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            pend_q;

  logic            wr_en_c, pop_req_c, clr_c, full_c, push_do_c, ovf_set_c;
  logic [EW-1:0]   head_c;
  logic            unused_bits_c;

  assign unused_bits_c = ^{cpu_addr_in[31:3], cpu_addr_in[1:0],
                           cpu_data_in[31:2], cpu_data_in[0]};

  // Prefix state register; reset drops any partial E0/F0 prefix.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Prefix decode: emits one event on the first non-prefix byte.
  always_comb begin
    state_d    = state_q;
    ev_valid_c = 1'b0;
    ev_word_c  = '0;
    if (kb_valid_in) begin
      case (state_q)
        S_IDLE: begin
          if (kb_scancode_in == CODE_EXT)      state_d = S_EXT;
          else if (kb_scancode_in == CODE_REL) state_d = S_REL;
          else begin
            ev_valid_c = 1'b1;
            ev_word_c  = {2'b00, kb_scancode_in};
          end
        end
        S_EXT: begin
          if (kb_scancode_in == CODE_REL)      state_d = S_EXT_REL;
          else if (kb_scancode_in != CODE_EXT) begin
            ev_valid_c = 1'b1;
            ev_word_c  = {2'b01, kb_scancode_in};
            state_d    = S_IDLE;
          end
        end
        S_REL: begin
          if (kb_scancode_in == CODE_EXT)      state_d = S_EXT_REL;
          else if (kb_scancode_in != CODE_REL) begin
            ev_valid_c = 1'b1;
            ev_word_c  = {2'b10, kb_scancode_in};
            state_d    = S_IDLE;
          end
        end
        default: begin
          if (kb_scancode_in != CODE_EXT && kb_scancode_in != CODE_REL) begin
            ev_valid_c = 1'b1;
            ev_word_c  = {2'b11, kb_scancode_in};
            state_d    = S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef KB_REPEAT_FILTER_EN
  logic [511:0] held_q, held_d;

  // Held-key bitmap: repeat makes are suppressed, releases always pass.
  always_comb begin
    held_d     = held_q;
    push_req_c = ev_valid_c;
    if (ev_valid_c) begin
      if (ev_word_c[9])                 held_d[ev_word_c[8:0]] = 1'b0;
      else if (held_q[ev_word_c[8:0]])  push_req_c = 1'b0;
      else                              held_d[ev_word_c[8:0]] = 1'b1;
    end
  end

  // Bitmap register, cleared on reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) held_q <= '0;
    else        held_q <= held_d;
  end
`else
  assign push_req_c = ev_valid_c;
`endif

  // FIFO control, overflow flag and read-data mux on post-edge state.
  always_comb begin
    wr_en_c   = |cpu_write_enable_in;
    pop_req_c = wr_en_c && cpu_addr_in[2] && (count_q != '0);
    clr_c     = wr_en_c && !cpu_addr_in[2] && cpu_data_in[1];
    full_c    = (count_q == CW'(DEPTH));
    push_do_c = push_req_c && (!full_c || pop_req_c);
    ovf_set_c = push_req_c && full_c && !pop_req_c;

    wr_ptr_d  = push_do_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_req_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push_do_c && !pop_req_c)      count_d = count_q + CW'(1);
    else if (!push_do_c && pop_req_c) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (clr_c)     ovf_d = 1'b0;
    if (ovf_set_c) ovf_d = 1'b1;

    // The entry written this edge becomes head when it lands on rd_ptr_d.
    head_c = '0;
    if (count_d != '0) begin
      if (push_do_c && (wr_ptr_q == rd_ptr_d)) head_c = ev_word_c;
      else                                     head_c = mem_q[rd_ptr_d];
    end

    if (cpu_addr_in[2]) rdata_d = {22'd0, head_c};
    else                rdata_d = {16'd0, 8'(count_d), 6'd0, ovf_d, (count_d != '0)};
  end

  // Pointer, count, flag and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      pend_q   <= (count_d != '0);
    end
  end

  // Event storage; contents need no reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_do_c) mem_q[wr_ptr_q] <= ev_word_c;
  end

  assign cpu_data_out    = rdata_q;
  assign key_pending_out = pend_q;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Bench for ps2_key_buffer: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
`timescale 1ns/1ps
module tb_ps2_key_buffer;

  localparam int unsigned DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        kb_valid_in = 1'b0;
  logic [7:0]  kb_scancode_in = '0;
  logic [31:0] cpu_addr_in = '0;
  logic [31:0] cpu_data_in = '0;
  logic [3:0]  cpu_write_enable_in = '0;
  logic [31:0] cpu_data_out;
  logic        key_pending_out;

  int checks = 0;
  int errors = 0;

  ps2_key_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .kb_valid_in(kb_valid_in),
    .kb_scancode_in(kb_scancode_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .cpu_write_enable_in(cpu_write_enable_in),
    .cpu_data_out(cpu_data_out), .key_pending_out(key_pending_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state.
  logic [9:0]   mq[$];
  bit           m_ovf = 0;
  bit           m_ext = 0;
  bit           m_rel = 0;
  bit [511:0]   m_held = '0;
  logic [31:0]  exp_data = '0;
  bit           exp_pend = 0;
  bit           chk_en = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: prefix flags, held-key set, and a queue of events.
  always @(posedge clk_in) begin
    bit       have, push, popok, wr, clr, ovfset;
    logic [9:0] ev;
    if (rst_in) begin
      mq.delete();
      m_ovf = 0; m_ext = 0; m_rel = 0; m_held = '0;
      exp_data = '0; exp_pend = 0;
      chk_en = 1;
    end else begin
      have = 0; ev = '0;
      if (kb_valid_in) begin
        if (kb_scancode_in == 8'hE0)      m_ext = 1;
        else if (kb_scancode_in == 8'hF0) m_rel = 1;
        else begin
          have = 1;
          ev = {m_rel, m_ext, kb_scancode_in};
          m_ext = 0; m_rel = 0;
        end
      end
      push = have;
`ifdef KB_REPEAT_FILTER_EN
      if (have) begin
        if (ev[9]) m_held[ev[8:0]] = 0;
        else if (m_held[ev[8:0]]) push = 0;
        else m_held[ev[8:0]] = 1;
      end
`endif
      wr = (cpu_write_enable_in != 0);
      popok = wr && cpu_addr_in[2] && (mq.size() > 0);
      clr = wr && !cpu_addr_in[2] && cpu_data_in[1];
      ovfset = push && (mq.size() == DEPTH) && !popok;
      if (popok) void'(mq.pop_front());
      if (push && !ovfset) mq.push_back(ev);
      if (clr) m_ovf = 0;
      if (ovfset) m_ovf = 1;
      if (cpu_addr_in[2])
        exp_data = (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
      else
        exp_data = (mq.size() << 8) | (int'(m_ovf) << 1) | int'(mq.size() > 0);
      exp_pend = (mq.size() > 0);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk_in) begin
    if (chk_en) begin
      check("cpu_data_out", cpu_data_out, exp_data);
      check("key_pending_out", 32'(key_pending_out), 32'(exp_pend));
    end
  end

  task automatic drive(input bit v, input logic [7:0] code, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] we);
    kb_valid_in = v; kb_scancode_in = code;
    cpu_addr_in = addr; cpu_data_in = data; cpu_write_enable_in = we;
    @(posedge clk_in);
    @(negedge clk_in);
    kb_valid_in = 0; cpu_write_enable_in = '0;
  endtask

  task automatic send(input logic [7:0] code);
    drive(1, code, 32'h0, 32'h0, 4'h0);
  endtask
  task automatic rd_status(input string nm, input logic [31:0] exp);
    drive(0, 8'h0, 32'h0, 32'h0, 4'h0);
    check(nm, cpu_data_out, exp);
  endtask
  task automatic rd_data(input string nm, input logic [31:0] exp);
    drive(0, 8'h0, 32'h4, 32'h0, 4'h0);
    check(nm, cpu_data_out, exp);
  endtask
  task automatic pop();
    drive(0, 8'h0, 32'h4, 32'hDEAD_BEEF, 4'hF);
  endtask
  task automatic do_reset();
    rst_in = 1;
    drive(0, 8'h0, 32'h0, 32'h0, 4'h0);
    rst_in = 0;
  endtask

  initial begin
    logic [9:0] exp_list[$];
    do_reset();
    // Reset state.
    rd_status("reset_status", 32'h0);
    check("reset_pending", 32'(key_pending_out), 32'h0);
    rd_data("reset_data", 32'h0);

    // Basic decode of all four prefix combinations.
    send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    rd_data("dec_make", 32'h01C); pop();
    rd_data("dec_ext", 32'h175);  pop();
    rd_data("dec_rel", 32'h21C);  pop();
    rd_data("dec_ext_rel", 32'h375); pop();
    rd_status("dec_empty", 32'h0);

    // Overflow: DEPTH+1 pushes.
    for (int i = 0; i <= DEPTH; i++) send(8'(8'h10 + i));
    rd_status("ovf_status", 32'h0000_1003);
    for (int i = 0; i < DEPTH; i++) begin
      rd_data("ovf_drain", 32'(8'h10 + i));
      pop();
    end
    rd_status("ovf_sticky", 32'h2);
    drive(0, 8'h0, 32'h0, 32'h2, 4'h1);
    check("ovf_clear_wr", cpu_data_out, 32'h0);
    rd_status("ovf_cleared", 32'h0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) send(8'(8'h40 + i));
    drive(1, 8'h33, 32'h4, 32'h0, 4'hF);
    check("full_pp_head", cpu_data_out, 32'h041);
    rd_status("full_pp_status", 32'h0000_1001);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    rd_data("full_pp_tail", 32'h033);
    pop();
    // Count of one with simultaneous push and pop.
    send(8'h50);
    drive(1, 8'h51, 32'h4, 32'h0, 4'h2);
    check("one_pp_head", cpu_data_out, 32'h051);
    rd_status("one_pp_status", 32'h0000_0101);
    pop();

    // Reset mid-prefix.
    send(8'hF0);
    do_reset();
    send(8'h1C);
    rd_data("rst_prefix", 32'h01C);
    pop();

    // Repeat filter behaviour.
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef KB_REPEAT_FILTER_EN
    exp_list = '{10'h01C, 10'h21C, 10'h01C};
    rd_status("rep_status", 32'h0000_0301);
`else
    exp_list = '{10'h01C, 10'h01C, 10'h01C, 10'h21C, 10'h01C};
    rd_status("rep_status", 32'h0000_0501);
`endif
    foreach (exp_list[i]) begin
      rd_data("rep_entry", 32'(exp_list[i]));
      pop();
    end
    rd_status("rep_empty", 32'h0);

    // Randomized traffic: push-heavy then pop-heavy phases.
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 2000; n++) begin
        logic [7:0] code;
        logic [3:0] we;
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
          0: code = 8'hE0;
          1: code = 8'hF0;
          2: code = 8'h1C;
          3: code = 8'h75;
          4: code = 8'hE1;
          default: code = 8'($urandom);
        endcase
        we = ($urandom_range(0, 9) < (ph == 0 ? 2 : 6)) ? 4'($urandom_range(1, 15)) : 4'h0;
        rst_in = ($urandom_range(0, 299) == 0);
        drive(1'($urandom_range(0, 1)), code, $urandom, $urandom, we);
        rst_in = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
